// File: rtl/lenet_fp16_pkg.sv
// Shared FP16 definitions for the LeNet pipeline stages.
// Field positions, special encodings and the argmax FSM states.
package lenet_fp16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MANT_MSB = 9;

  localparam logic [4:0] EXP_ALL_ONES = 5'h1F;

  localparam logic [15:0] POS_ZERO  = 16'h0000;
  localparam logic [15:0] NEG_ZERO  = 16'h8000;
  localparam logic [15:0] POS_INF   = 16'h7C00;
  localparam logic [15:0] CANON_NAN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/Float16Greater.sv
// FP16 ordering comparator: a_gt_b is high when floatA should replace floatB
// as a running maximum. Ports: floatA, floatB in; a_gt_b, a_is_nan, b_is_nan out.
module Float16Greater
  import lenet_fp16_pkg::*;
(
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic        a_gt_b,
  output logic        a_is_nan,
  output logic        b_is_nan
);

  logic [14:0] mag_a;
  logic [14:0] mag_b;
  logic        sign_a;
  logic        sign_b;
  logic        both_zero;
  logic        ordered_gt;

  assign mag_a  = floatA[EXP_MSB:0];
  assign mag_b  = floatB[EXP_MSB:0];
  assign sign_a = floatA[SIGN_BIT];
  assign sign_b = floatB[SIGN_BIT];

  assign a_is_nan = (floatA[EXP_MSB:EXP_LSB] == EXP_ALL_ONES)
                 && (floatA[MANT_MSB:0] != '0);
  assign b_is_nan = (floatB[EXP_MSB:EXP_LSB] == EXP_ALL_ONES)
                 && (floatB[MANT_MSB:0] != '0);

  // +0 and -0 must compare equal across the sign split
  assign both_zero = (mag_a == '0) && (mag_b == '0);

  always_comb begin
    ordered_gt = 1'b0;
    unique case ({sign_a, sign_b})
      2'b00:   ordered_gt = mag_a > mag_b;
      2'b01:   ordered_gt = !both_zero;
      2'b10:   ordered_gt = 1'b0;
      2'b11:   ordered_gt = mag_a < mag_b;
      default: ordered_gt = 1'b0;
    endcase
  end

  // a NaN never wins; anything real beats a NaN incumbent
  assign a_gt_b = !a_is_nan && (b_is_nan || ordered_gt);

endmodule

// File: rtl/fp16_argmax_classifier.sv
// Latches an FP16 score vector and scans it one element per cycle for argmax.
// Ports: clk, reset, start, scores in; ready, busy, done, class_idx, max_score, all_nan out.
module fp16_argmax_classifier
  import lenet_fp16_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores,
  output logic                              ready,
  output logic                              busy,
  output logic                              done,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             max_score,
  output logic                              all_nan
);

  localparam int CW = $clog2(NUM_CLASSES);

  state_t state;
  state_t state_nx;

  logic [DATA_WIDTH-1:0] score_q [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] best_val;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [CW-1:0]         idx;
  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_wins;
  logic                  cand_nan;
  logic                  best_nan;
  logic                  last;

  assign cand = score_q[idx];
  assign last = (idx == CW'(NUM_CLASSES - 1));

  // best_nan is derived from best_val rather than stored separately
  Float16Greater u_cmp (
    .floatA   (cand),
    .floatB   (best_val),
    .a_gt_b   (cand_wins),
    .a_is_nan (cand_nan),
    .b_is_nan (best_nan)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++)
        score_q[i] <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      idx       <= '0;
      class_idx <= '0;
      max_score <= POS_ZERO;
      all_nan   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              score_q[i] <= scores[i*DATA_WIDTH +: DATA_WIDTH];
            best_val <= scores[DATA_WIDTH-1:0];
            best_idx <= '0;
            idx      <= CW'(1);
          end
        end
        SCAN: begin
          if (cand_wins) begin
            best_val <= cand;
            best_idx <= IDX_WIDTH'(idx);
          end
          idx <= idx + CW'(1);
          // publish including the final comparison made this edge
          if (last) begin
            class_idx <= cand_wins ? IDX_WIDTH'(idx) : best_idx;
            max_score <= cand_wins ? cand : best_val;
            all_nan   <= cand_wins ? cand_nan : best_nan;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
